// File: rtl/gpio_pkg.sv
// gpio_pkg: shared bus geometry and register map of the GPIO input-capture block.
package gpio_pkg;
    localparam int ADDR_W = 3;
    localparam int DATA_W = 32;
    localparam logic [ADDR_W-1:0] GPIO_REG_DATA     = 3'd0;
    localparam logic [ADDR_W-1:0] GPIO_REG_RAW      = 3'd1;
    localparam logic [ADDR_W-1:0] GPIO_REG_IRQ_MASK = 3'd2;
    localparam logic [ADDR_W-1:0] GPIO_REG_CAPTURE  = 3'd3;
    localparam logic [ADDR_W-1:0] GPIO_REG_RISE_EN  = 3'd4;
    localparam logic [ADDR_W-1:0] GPIO_REG_FALL_EN  = 3'd5;
endpackage

// File: rtl/gpio_debounce_bit.sv
// gpio_debounce_bit: synchroniser chain plus tick-paced debouncer for one pin.
module gpio_debounce_bit #(
    parameter int SYNC_STAGES = 2,
    parameter int DB_SAMPLES  = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic pin_i,
    input  logic tick_i,
    output logic sync_o,
    output logic stable_o
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic [2:0]             cnt_q, cnt_d;
    logic                   stable_q, stable_d;

    assign sync_o   = sync_q[SYNC_STAGES-1];
    assign stable_o = stable_q;

    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (tick_i) begin
            if (sync_o == stable_q) begin
                cnt_d = '0;
            end else if (cnt_q == 3'(DB_SAMPLES - 1)) begin
                stable_d = sync_o;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], pin_i};
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end
endmodule

// File: rtl/gpio_input_capture.sv
// gpio_input_capture: debounced, edge-capturing GPIO inputs behind an Avalon-MM slave
// with a registered level interrupt.
module gpio_input_capture
    import gpio_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int TICK_DIV    = 25000,
    parameter int DB_SAMPLES  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  pins_i,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [DATA_W-1:0] avs_writedata,
    output logic [DATA_W-1:0] avs_readdata,
    output logic              irq
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0]     pre_q, pre_d;
    logic              tick;
    logic [WIDTH-1:0]  sync, stable, stable_dly_q;
    logic [WIDTH-1:0]  mask_q, mask_d, cap_q, cap_d, rise_en_q, rise_en_d, fall_en_q, fall_en_d;
    logic [WIDTH-1:0]  wdat, edge_hit;
    logic [DATA_W-1:0] rd_val, readdata_q;
    logic              irq_q;
    logic              unused_wdata;

    assign tick         = pre_q == PW'(TICK_DIV - 1);
    assign pre_d        = tick ? '0 : pre_q + PW'(1);
    assign wdat         = avs_writedata[WIDTH-1:0];
    assign unused_wdata = ^avs_writedata;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        gpio_debounce_bit #(
            .SYNC_STAGES(SYNC_STAGES),
            .DB_SAMPLES (DB_SAMPLES)
        ) u_db (
            .clk     (clk),
            .reset   (reset),
            .pin_i   (pins_i[i]),
            .tick_i  (tick),
            .sync_o  (sync[i]),
            .stable_o(stable[i])
        );
    end

    assign edge_hit = (stable & ~stable_dly_q & rise_en_q) | (~stable & stable_dly_q & fall_en_q);

    // Set wins over a same-cycle W1C of the same bit.
    always_comb begin
        mask_d    = (avs_write && avs_address == GPIO_REG_IRQ_MASK) ? wdat : mask_q;
        rise_en_d = (avs_write && avs_address == GPIO_REG_RISE_EN)  ? wdat : rise_en_q;
        fall_en_d = (avs_write && avs_address == GPIO_REG_FALL_EN)  ? wdat : fall_en_q;
        cap_d     = (cap_q & ~((avs_write && avs_address == GPIO_REG_CAPTURE) ? wdat : '0)) | edge_hit;
        case (avs_address)
            GPIO_REG_DATA:     rd_val = DATA_W'(stable);
            GPIO_REG_RAW:      rd_val = DATA_W'(sync);
            GPIO_REG_IRQ_MASK: rd_val = DATA_W'(mask_q);
            GPIO_REG_CAPTURE:  rd_val = DATA_W'(cap_q);
            GPIO_REG_RISE_EN:  rd_val = DATA_W'(rise_en_q);
            GPIO_REG_FALL_EN:  rd_val = DATA_W'(fall_en_q);
            default:           rd_val = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q        <= '0;
            stable_dly_q <= '0;
            mask_q       <= '0;
            cap_q        <= '0;
            rise_en_q    <= '0;
            fall_en_q    <= '0;
            readdata_q   <= '0;
            irq_q        <= 1'b0;
        end else begin
            pre_q        <= pre_d;
            stable_dly_q <= stable;
            mask_q       <= mask_d;
            cap_q        <= cap_d;
            rise_en_q    <= rise_en_d;
            fall_en_q    <= fall_en_d;
            readdata_q   <= avs_read ? rd_val : readdata_q;
            irq_q        <= |(cap_q & mask_q);
        end
    end

    assign avs_readdata = readdata_q;
    assign irq          = irq_q;
endmodule
